fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the multicycle RV32I core. It sits directly upstream of the decode/register-file/execute path inside top.
- Owns the program counter and issues word reads to the synchronous instruction memory, which is initialised from INIT_FILE.
- Presents each fetched instruction, with its PC and PC+4, to the downstream stage over a valid/ready handshake.
- Accepts redirects for taken branches and jumps. Supplies the exact instruction PC that AUIPC, JAL and JALR consume.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
- ADDR_WIDTH, 32, width of PC and of the memory byte address.

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_WIDTH  byte address of the read; bits [1:0] always 0
- imem_rdata  in  32  read data, valid on the cycle after imem_req (1-cycle synchronous BRAM)
- instr_valid  out  1  instr/instr_pc/instr_pc_plus4 hold a valid fetched instruction
- instr_ready  in  1  downstream accepts the instruction this cycle
- instr  out  32  fetched instruction word
- instr_pc  out  ADDR_WIDTH  PC of instr
- instr_pc_plus4  out  ADDR_WIDTH  instr_pc + 4
- redirect_valid  in  1  single-cycle request to change the PC
- redirect_pc  in  ADDR_WIDTH  target address; bits [1:0] ignored

Behaviour:
- Reset (async assert, sync release): pc = RESET_PC, state = FETCH, instr_valid = 0, imem_req = 0, instr = 32'h0000_0013 (NOP), instr_pc = RESET_PC, instr_pc_plus4 = RESET_PC + 4.
- imem_req is combinational: 1 exactly when state == FETCH and reset is low. imem_addr = pc at all times.
- FETCH state:
  - Drive imem_req = 1 and imem_addr = pc.
  - Next state is WAIT.
- WAIT state:
  - Register instr <= imem_rdata, instr_pc <= pc, instr_pc_plus4 <= pc + 4, instr_valid <= 1.
  - Next state is VALID.
- VALID state:
  - Hold all outputs stable while instr_ready = 0; there is no timeout.
  - On instr_valid & instr_ready: pc <= pc + 4, instr_valid <= 0, next state FETCH.
- Latency: 2 cycles from a FETCH cycle to instr_valid = 1. Best-case throughput is one instruction per 3 cycles (FETCH, WAIT, VALID with ready = 1).
- Redirect:
  - redirect_valid has highest priority in every state: pc <= {redirect_pc[31:2], 2'b00}, instr_valid <= 0, next state FETCH.
  - Redirect in WAIT: the returning imem_rdata is discarded and never presented.
  - Redirect in the same cycle as a handshake: the handshake completes (downstream owns that instruction), the PC takes the redirect target rather than pc + 4, and the next fetch is from the target.
  - Back-to-back redirects: the last one wins.
- Arithmetic: pc + 4 wraps modulo 2^ADDR_WIDTH with no flag; 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-operation: all state returns to reset values immediately, with no memory strobe that cycle. An in-flight read is dropped.
- instr_valid never deasserts without a handshake or a redirect.
- Outputs are undefined-free: no X ever propagates while instr_valid = 0.

Decomposition:
- Shared package core_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, VALID};
  - NOP_INSTR = 32'h0000_0013;
  - XLEN = 32.
- No sub-module; the single FSM plus PC register live in fetch_unit.
- Instruction memory stays a separate existing block and is instantiated in top, not here.

Test Plan:
- Reset release with RESET_PC = 0, memory words 0..3 = 00500093, 00A00113, 123451B7, 00001217, instr_ready held 1 -> instructions appear in order with instr_pc = 0, 4, 8, 12, each instr_valid one cycle wide, 3 cycles apart.
- Backpressure: hold instr_ready = 0 for 10 cycles after the first instr_valid -> instr = 00500093 and instr_pc = 0 stay stable, no imem_req. Raise ready -> next fetch is from addr 4.
- Redirect in WAIT to 32'h0000_0040 -> the word from the old address is never presented, the next instr_valid carries instr_pc = 0x40, and instr_pc_plus4 = 0x44.
- Redirect coincident with handshake, target 32'h0000_0103 -> handshake counts, next imem_addr = 0x100, instr_pc = 0x100.
- AUIPC support: fetch 00001217 at PC 12 -> instr_pc = 0x0000_000C and instr_pc_plus4 = 0x10. With the full core, x4 = 0x0000_100C exactly.
- Async reset asserted during VALID -> instr_valid = 0 before the next clock edge. After release, the first imem_addr is RESET_PC. Also: redirect to 0xFFFF_FFFC then handshake -> next imem_addr = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I multicycle core.
// Fetch FSM encoding and the canonical NOP live here.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, strobes the sync imem,
// and hands {instr, pc, pc+4} downstream over valid/ready.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]       imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [XLEN-1:0]       instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic [ADDR_WIDTH-1:0] ipc4_q, ipc4_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redir_aligned;

  assign pc_plus4      = pc_q + FOUR;
  assign redir_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // Memory strobe is suppressed while reset is held.
  assign imem_req       = (state_q == FETCH) && !reset;
  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_pc_plus4 = ipc4_q;

  // Next-state: redirect overrides everything, and a redirect
  // during WAIT leaves the output regs untouched so the stale word
  // is never latched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    if (redirect_valid) begin
      pc_d    = redir_aligned;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: state_d = WAIT;
        WAIT: begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4;
          valid_d = 1'b1;
          state_d = VALID;
        end
        VALID: begin
          if (valid_q && instr_ready) begin
            pc_d    = pc_plus4;
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      endcase
    end
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      ipc4_q  <= RESET_PC + FOUR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random
// redirect/backpressure against a transaction-level model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks;
  int n_errors;

  // Reference: address the model expects next, and cycles left
  // before that instruction must be presented (0 = presented now).
  logic [31:0] m_pc;
  int          m_lat;
  int          n_hs;

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus4(instr_pc_plus4),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h1234_51B7;
      32'hC:   return 32'h0000_1217;
      default: return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endcase
  endfunction

  // 1-cycle synchronous instruction memory.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_lat = 2;
  endtask

  // Called at a negedge: drive inputs, check, advance one edge.
  task automatic cycle(input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
    chk("imem_addr", imem_addr, m_pc);
    if (m_lat == 0) begin
      chk("valid", {31'b0, instr_valid}, 32'd1);
      chk("instr", instr, mem_word(m_pc));
      chk("instr_pc", instr_pc, m_pc);
      chk("pc_plus4", instr_pc_plus4, m_pc + 32'd4);
      chk("req_in_valid", {31'b0, imem_req}, 32'd0);
      if (instr == 32'h0000_1217 && instr_pc == 32'hC)
        chk("auipc_x4", instr_pc + {instr[31:12], 12'h0},
            32'h0000_100C);
    end else begin
      chk("valid", {31'b0, instr_valid}, 32'd0);
      chk("imem_req", {31'b0, imem_req},
          (m_lat == 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    if (rv) begin
      m_pc  = {rpc[31:2], 2'b00};
      m_lat = 2;
    end else if (m_lat == 0) begin
      if (rdy) begin
        m_pc  = m_pc + 32'd4;
        m_lat = 2;
      end
    end else begin
      m_lat = m_lat - 1;
    end
    if (m_lat == 0 && !rv) n_hs = n_hs;
    if (rdy && instr_valid) n_hs++;
    @(negedge clk);
  endtask

  task automatic run_until_lat(input int lat, input logic rdy);
    int guard;
    guard = 0;
    while (m_lat != lat && guard < 20) begin
      cycle(1'b0, 32'h0, rdy);
      guard++;
    end
    chk("reach_state", (m_lat == lat) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    n_hs           = 0;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_pc4", instr_pc_plus4, 32'h4);
    reset = 1'b0;

    // Backpressure on the first instruction, then stream.
    run_until_lat(0, 1'b0);
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
    repeat (14) cycle(1'b0, 32'h0, 1'b1);
    chk("stream_pc", m_pc, 32'h14);

    // Async reset while an instruction is presented.
    run_until_lat(0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", {31'b0, instr_valid}, 32'd0);
    chk("areset_req", {31'b0, imem_req}, 32'd0);
    chk("areset_instr", instr, 32'h0000_0013);
    chk("areset_pc", instr_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b1);

    // Redirect during WAIT; old word must never appear.
    run_until_lat(1, 1'b1);
    cycle(1'b1, 32'h40, 1'b1);
    run_until_lat(0, 1'b0);
    chk("redir_wait_pc", instr_pc, 32'h40);
    chk("redir_wait_pc4", instr_pc_plus4, 32'h44);

    // Redirect coincident with handshake, misaligned target.
    cycle(1'b1, 32'h103, 1'b1);
    chk("redir_hs_addr", imem_addr, 32'h100);
    run_until_lat(0, 1'b1);
    chk("redir_hs_ipc", instr_pc, 32'h100);

    // Back-to-back redirects, last one wins; wrap at top.
    cycle(1'b1, 32'h200, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
    run_until_lat(0, 1'b0);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", instr_pc_plus4, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Random redirects and backpressure.
    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cycle(rv, rpc, ($urandom_range(0, 9) < 7));
    end
    chk("handshakes_seen", (n_hs > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
